inst_loader: RTL and testbench

- Boot-time writer for the 9-bit instruction memory. The core fetch path only reads that memory; this block fills it.
- Accepts a stream of instruction words over a valid/ready handshake and issues sequential writes from address 0.
- Verifies a trailing checksum word, then releases the CPU from hold.
- Sits between the host/testbench download port and the instruction memory's write port.

---
 rtl/inst_loader.sv | 141 ++++++++++++++
 tb/tb_inst_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Boot-time instruction memory loader: streams words into sequential addresses,
// verifies a trailing modular checksum, then releases the CPU from hold.
module inst_loader #(
  parameter int unsigned IW = 8,
  parameter int unsigned W  = 9
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic [IW:0]   load_len,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [IW-1:0] wr_addr,
  output logic [W-1:0]  wr_data,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          cpu_hold
);

  localparam logic [IW:0] MAX_LEN = {1'b1, {IW{1'b0}}};
  localparam logic [IW:0] ONE     = (IW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_FAIL
  } state_t;

  state_t         state_q;
  logic [IW:0]    count_q;
  logic [IW:0]    len_q;
  logic [W-1:0]   sum_q;
  logic           in_ready_q;
  logic           wr_en_q;
  logic [IW-1:0]  wr_addr_q;
  logic [W-1:0]   wr_data_q;
  logic           busy_q;
  logic           done_q;
  logic           error_q;
  logic           cpu_hold_q;

  logic           len_ok;
  logic           xfer;
  logic           last_word;

  assign len_ok    = (load_len != '0) && (load_len <= MAX_LEN);
  assign xfer      = in_valid && in_ready_q;
  assign last_word = (count_q == (len_q - ONE));

  // Single-process FSM; every output is a register updated with the state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      len_q      <= '0;
      sum_q      <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cpu_hold_q <= 1'b1;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            done_q     <= 1'b0;
            cpu_hold_q <= 1'b1;
            if (len_ok) begin
              state_q    <= S_LOAD;
              count_q    <= '0;
              sum_q      <= '0;
              len_q      <= load_len;
              error_q    <= 1'b0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              state_q <= S_FAIL;
              error_q <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (xfer) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= count_q[IW-1:0];
            wr_data_q <= in_data;
            count_q   <= count_q + ONE;
            sum_q     <= sum_q + in_data;
            if (last_word) begin
              state_q <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          // Checksum word is compared only, never written to memory.
          if (xfer) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (in_data == sum_q) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q    <= S_FAIL;
              error_q    <= 1'b1;
              cpu_hold_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          cpu_hold_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_inst_loader.sv
// Randomized self-checking bench for inst_loader with a transaction-level model.
module tb_inst_loader;

  localparam int IW = 8;
  localparam int W  = 9;
  localparam int DEPTH = 1 << IW;

  localparam int M_IDLE = 0, M_LOAD = 1, M_CHECK = 2, M_DONE = 3, M_FAIL = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          start = 1'b0;
  logic [IW:0]   load_len = '0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, wr_en, busy, done, error, cpu_hold;
  logic [IW-1:0] wr_addr;
  logic [W-1:0]  wr_data;

  inst_loader #(.IW(IW), .W(W)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: mode plus the list of accepted words; word k belongs at address k.
  int         m_mode = M_IDLE;
  int         m_len  = 0;
  int         m_words[$];
  logic       e_wr_en = 1'b0;
  int         e_wr_addr = 0;
  int         e_wr_data = 0;

  function automatic int list_sum();
    int s = 0;
    foreach (m_words[i]) s += m_words[i];
    return s % (1 << W);
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_mode  <= M_IDLE;
      e_wr_en <= 1'b0;
      e_wr_addr <= 0;
      e_wr_data <= 0;
      m_words.delete();
    end else begin
      e_wr_en <= 1'b0;
      if (m_mode == M_LOAD) begin
        if (in_valid) begin
          e_wr_en   <= 1'b1;
          e_wr_addr <= m_words.size();
          e_wr_data <= int'(in_data);
          m_words.push_back(int'(in_data));
          if (m_words.size() == m_len) m_mode <= M_CHECK;
        end
      end else if (m_mode == M_CHECK) begin
        if (in_valid) m_mode <= (int'(in_data) == list_sum()) ? M_DONE : M_FAIL;
      end else if (start) begin
        m_words.delete();
        m_len  <= int'(load_len);
        m_mode <= (load_len >= 1 && int'(load_len) <= DEPTH) ? M_LOAD : M_FAIL;
      end
    end
  end

  logic e_rdy;
  assign e_rdy = (m_mode == M_LOAD) || (m_mode == M_CHECK);

  // Write log captured from the DUT, plus the cycle each write was seen.
  logic [IW+W-1:0] wr_log[$];
  int              wr_cyc[$];
  int              cyc_cnt = 0;
  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge Clk) begin
    chk("in_ready", int'(in_ready), int'(e_rdy));
    chk("busy", int'(busy), int'(e_rdy));
    chk("done", int'(done), int'(m_mode == M_DONE));
    chk("error", int'(error), int'(m_mode == M_FAIL));
    chk("cpu_hold", int'(cpu_hold), int'(m_mode != M_DONE));
    chk("wr_en", int'(wr_en), int'(e_wr_en));
    if (wr_en && e_wr_en) begin
      chk("wr_addr", int'(wr_addr), e_wr_addr);
      chk("wr_data", int'(wr_data), e_wr_data);
    end
    if (wr_en) begin
      wr_log.push_back({wr_addr, wr_data});
      wr_cyc.push_back(cyc_cnt);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // vmode: 0 valid held high, 1 toggled, 2 random. start_at: cycle to pulse start mid-load.
  task automatic run_load(input int len, input int words[$], input bit corrupt,
                          input int vmode, input int start_at);
    int q[$];
    int s = 0;
    int idx = 0;
    int cyc = 0;
    bit v;
    wr_log.delete();
    wr_cyc.delete();
    start = 1'b1;
    load_len = (IW+1)'(len);
    tick();
    start = 1'b0;
    if (len >= 1 && len <= DEPTH) begin
      q = words;
      foreach (words[i]) s = (s + words[i]) % (1 << W);
      if (corrupt) s = (s + 1) % (1 << W);
      q.push_back(s);
      while (idx < q.size() && cyc < 3000) begin
        v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
        in_valid = v;
        in_data  = v ? W'(q[idx]) : W'($urandom);
        start    = (cyc == start_at);
        load_len = (IW+1)'($urandom);
        if (v && e_rdy) idx++;
        tick();
        cyc++;
      end
      if (cyc >= 3000) chk("stream_timeout", cyc, 0);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    tick();
    tick();
  endtask

  task automatic chk_log(input string name, input int words[$]);
    chk({name, "_nwr"}, wr_log.size(), words.size());
    foreach (wr_log[i])
      if (i < words.size()) chk({name, "_wr"}, int'(wr_log[i]), (i << W) | words[i]);
  endtask

  initial begin
    int w[$];
    int len;
    bit bad;
    tick();
    tick();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_cpu_hold", int'(cpu_hold), 1);
    Reset = 1'b0;
    tick();

    // Good 3-word load; literal expectations pin the model.
    w = '{1, 2, 'h1FF};
    run_load(3, w, 1'b0, 0, -1);
    chk("t1_nwr", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      chk("t1_w0", int'(wr_log[0]), (0 << W) | 'h001);
      chk("t1_w1", int'(wr_log[1]), (1 << W) | 'h002);
      chk("t1_w2", int'(wr_log[2]), (2 << W) | 'h1FF);
      chk("t1_consecutive", wr_cyc[2] - wr_cyc[0], 2);
    end
    chk("t1_done", int'(done), 1);
    chk("t1_error", int'(error), 0);
    chk("t1_hold", int'(cpu_hold), 0);

    // Bad checksum (0x003), then recovery.
    run_load(3, w, 1'b1, 0, -1);
    chk("t2_nwr", wr_log.size(), 3);
    chk("t2_error", int'(error), 1);
    chk("t2_done", int'(done), 0);
    chk("t2_hold", int'(cpu_hold), 1);
    run_load(3, w, 1'b0, 0, -1);
    chk("t2_done_after", int'(done), 1);

    // Illegal lengths.
    w.delete();
    run_load(0, w, 1'b0, 0, -1);
    chk("t3_len0_nwr", wr_log.size(), 0);
    chk("t3_len0_error", int'(error), 1);
    chk("t3_len0_hold", int'(cpu_hold), 1);
    run_load(257, w, 1'b0, 0, -1);
    chk("t3_len257_nwr", wr_log.size(), 0);
    chk("t3_len257_error", int'(error), 1);

    // Full depth, data = address.
    w.delete();
    for (int i = 0; i < DEPTH; i++) w.push_back(i);
    run_load(DEPTH, w, 1'b0, 0, -1);
    chk_log("t4", w);
    if (wr_log.size() == DEPTH) chk("t4_last_addr", int'(wr_log[DEPTH-1][IW+W-1:W]), 'hFF);
    chk("t4_done", int'(done), 1);

    // Toggled valid with a start pulse mid-load.
    w = '{'h10, 'h20, 'h30, 'h40};
    run_load(4, w, 1'b0, 1, 3);
    chk_log("t5", w);
    chk("t5_done", int'(done), 1);

    // Asynchronous reset after 2 of 5 words.
    start = 1'b1; load_len = 5; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 'h0AA; tick();
    in_data = 'h055; tick();
    in_valid = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("t6_rst_wr_en", int'(wr_en), 0);
    chk("t6_rst_in_ready", int'(in_ready), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_hold", int'(cpu_hold), 1);
    chk("t6_rst_wr_addr", int'(wr_addr), 0);
    tick();
    Reset = 1'b0;
    tick();
    w = '{'h123, 'h0F0};
    run_load(2, w, 1'b0, 0, -1);
    chk_log("t6_after", w);
    chk("t6_done", int'(done), 1);

    // Randomized loads.
    for (int r = 0; r < 10; r++) begin
      len = $urandom_range(1, 24);
      bad = ($urandom_range(0, 3) == 0);
      w.delete();
      for (int i = 0; i < len; i++) w.push_back(int'($urandom_range(0, (1 << W) - 1)));
      run_load(len, w, bad, 2, int'($urandom_range(0, 2 * len)));
      chk_log("rnd", w);
      chk("rnd_done", int'(done), int'(!bad));
      chk("rnd_error", int'(error), int'(bad));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
